seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. Drives the shared segment bus and four anodes. Each
// digit slot is a blanking gap followed by a drive period. A 16-bit BCD value
// is double-buffered (shadow -> active) and only swapped at a frame boundary,
// so a half-updated number is never displayed.
//
// Optional build macro: SEG_LZ_BLANK_EN - when defined, leading zeros on
// digits 1..3 are blanked. Digit 0 is never blanked, and slot timing does not
// change.
//
// Ports:
//   clk_i         system clock, rising edge
//   clr_n_i       synchronous active-low clear
//   enable_i      1 = scanning, 0 = display dark
//   load_i        single-cycle strobe, captures value_i into the shadow register
//   value_i       four BCD nibbles, [3:0] = digit0 (rightmost)
//   seg_o         active-low segments {g,f,e,d,c,b,a}
//   an_o          active-low anodes, an_o[i] = digit i
//   pending_o     shadow holds a value that is not yet displayed
//   frame_tick_o  one-cycle pulse on the last drive cycle of digit 3
//
// state  | meaning
// GAP    | all anodes off, guard time before the next digit
// DRIVE  | anode idx on, segments show nibble idx of the active value
module seg_scan_ctrl #(
   parameter int unsigned DigitCycles = 100_000,
   parameter int unsigned GapCycles   = 1_000,
   parameter int unsigned CntBits     = 17
) (
   input  logic        clk_i,
   input  logic        clr_n_i,
   input  logic        enable_i,
   input  logic        load_i,
   input  logic [15:0] value_i,
   output logic [6:0]  seg_o,
   output logic [3:0]  an_o,
   output logic        pending_o,
   output logic        frame_tick_o
);

   typedef enum logic {ST_GAP, ST_DRIVE} state_e;

   localparam logic [CntBits-1:0] GAP_LAST   = CntBits'(GapCycles - 1);
   localparam logic [CntBits-1:0] DIGIT_LAST = CntBits'(DigitCycles - 1);

   state_e               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [CntBits-1:0]   timer_q, timer_d;
   logic [15:0]          shadow_q, shadow_d;
   logic [15:0]          active_q, active_d;
   logic                 pending_q, pending_d;
   logic [6:0]           seg_q, seg_d;
   logic [3:0]           an_q, an_d;
   logic                 tick_q, tick_d;
   logic                 boundary;
   logic                 dark;
   logic [3:0]           nibble;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign boundary = (state_q == ST_DRIVE) && (idx_q == 2'd3) && (timer_q == DIGIT_LAST);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;

      if (!enable_i) begin
         state_d = ST_GAP;
         idx_d   = 2'd0;
         timer_d = '0;
         // Nothing is on screen, so a waiting value can go live at once.
         if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
         if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_GAP: begin
               if (timer_q == GAP_LAST) begin
                  state_d = ST_DRIVE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               if (timer_q == DIGIT_LAST) begin
                  state_d = ST_GAP;
                  idx_d   = idx_q + 2'd1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         endcase

         if (boundary) begin
            // A load landing on the boundary bypasses the shadow wait.
            if (load_i) begin
               active_d  = value_i;
               shadow_d  = value_i;
               pending_d = 1'b0;
            end else if (pending_q) begin
               active_d  = shadow_q;
               pending_d = 1'b0;
            end
         end else if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
         end
      end

      // Outputs are computed from next state so they register with it.
      nibble = active_d[{idx_d, 2'b00} +: 4];
      dark   = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      dark   = (idx_d != 2'd0) && ((active_d >> {idx_d, 2'b00}) == 16'h0000);
`endif
      seg_d  = 7'b1111111;
      an_d   = 4'b1111;
      if (state_d == ST_DRIVE && !dark) begin
         an_d[idx_d] = 1'b0;
         seg_d       = seg_decode(nibble);
      end
      tick_d = (state_d == ST_DRIVE) && (idx_d == 2'd3) && (timer_d == DIGIT_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (!clr_n_i) begin
         state_q   <= ST_GAP;
         idx_q     <= 2'd0;
         timer_q   <= '0;
         shadow_q  <= 16'h0000;
         active_q  <= 16'h0000;
         pending_q <= 1'b0;
         seg_q     <= 7'b1111111;
         an_q      <= 4'b1111;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         tick_q    <= tick_d;
      end
   end

   assign seg_o        = seg_q;
   assign an_o         = an_q;
   assign pending_o    = pending_q;
   assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DigitCycles = 4, GapCycles = 2 (24-cycle frame).
// Directed vector table, hand-written corner sequences, then random stimulus
// checked against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int D     = 4;
   localparam int G     = 2;
   localparam int SLOT  = D + G;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        en = 1'b1;
   logic        ld = 1'b0;
   logic [15:0] val = 16'h0000;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        pend;
   logic        ft;

   int n_vec = 0;
   int n_err = 0;

   // reference model: position within the frame plus the two buffers
   int          m_pos = 0;
   logic [15:0] m_act = 16'h0;
   logic [15:0] m_sh  = 16'h0;
   logic        m_pend = 1'b0;

   seg_scan_ctrl #(.DigitCycles(D), .GapCycles(G), .CntBits(3)) dut (
      .clk_i(clk), .clr_n_i(clr_n), .enable_i(en), .load_i(ld), .value_i(val),
      .seg_o(seg), .an_o(an), .pending_o(pend), .frame_tick_o(ft)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic logic [12:0] model_out();
      logic [6:0]  s = 7'h7F;
      logic [3:0]  a = 4'hF;
      int          slot;
      logic [15:0] upper;
      logic        blank;
      slot = m_pos / SLOT;
      if ((m_pos % SLOT) >= G) begin
         upper = m_act >> (4 * slot);
         blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
         blank = (slot > 0) && (upper == 16'h0);
`endif
         if (!blank) begin
            a[slot] = 1'b0;
            s = dec(upper[3:0]);
         end
      end
      return {s, a, m_pend, (m_pos == FRAME - 1)};
   endfunction

   task automatic model_edge(input logic c, input logic e, input logic l, input logic [15:0] v);
      if (!c) begin
         m_pos = 0; m_act = 0; m_sh = 0; m_pend = 0;
      end else if (!e) begin
         if (m_pend) begin m_act = m_sh; m_pend = 0; end
         if (l) begin m_sh = v; m_pend = 1; end
         m_pos = 0;
      end else begin
         if (m_pos == FRAME - 1) begin
            if (l) begin m_act = v; m_sh = v; m_pend = 0; end
            else if (m_pend) begin m_act = m_sh; m_pend = 0; end
         end else if (l) begin
            m_sh = v; m_pend = 1;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   task automatic step(input logic c, input logic e, input logic l, input logic [15:0] v);
      clr_n = c; en = e; ld = l; val = v;
      @(posedge clk);
      model_edge(c, e, l, v);
      #1;
   endtask

   task automatic chk(input string name, input logic [12:0] exp);
      logic [12:0] got;
      got = {seg, an, pend, ft};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got seg=%h an=%h pend=%b tick=%b, want seg=%h an=%h pend=%b tick=%b",
                  name, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic chk_bit(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b", name, got, exp);
      end
   endtask

   task automatic run_until_ft(input string name);
      for (int k = 0; k < 40 && ft !== 1'b1; k++) step(1, 1, 0, 16'h0);
      chk_bit(name, ft, 1'b1);
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) step(1, 1, 0, 16'h0);
   endtask

   typedef struct {
      logic        c, e, l;
      logic [15:0] v;
      logic [6:0]  s;
      logic [3:0]  a;
      logic        p, f;
   } vec_t;

   vec_t tbl[10];

   localparam logic [10:0] LZ_D1 =
`ifdef SEG_LZ_BLANK_EN
      {7'h7F, 4'hF};
`else
      {7'h40, 4'hD};
`endif
   localparam logic [10:0] LZ_D2 =
`ifdef SEG_LZ_BLANK_EN
      {7'h7F, 4'hF};
`else
      {7'h40, 4'hB};
`endif
   localparam logic [10:0] LZ_D3 =
`ifdef SEG_LZ_BLANK_EN
      {7'h7F, 4'hF};
`else
      {7'h40, 4'h7};
`endif

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h40, 4'hE, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h40, 4'hE, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h1234, 7'h40, 4'hE, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h40, 4'hE, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 16'h0000, LZ_D1[10:4], LZ_D1[3:0], 1'b1, 1'b0};

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].c, tbl[i].e, tbl[i].l, tbl[i].v);
         chk($sformatf("tbl%0d", i), {tbl[i].s, tbl[i].a, tbl[i].p, tbl[i].f});
      end

      // mid-frame load 1234 becomes visible only after the frame boundary
      run_until_ft("ft_1234");
      chk_bit("pend_on_tick", pend, 1'b1);
      step(1, 1, 0, 16'h0);
      chk("pend_clear", {7'h7F, 4'hF, 1'b0, 1'b0});
      run_n(2);
      chk("d0_1234", {7'h19, 4'hE, 1'b0, 1'b0});
      run_n(6);
      chk("d1_1234", {7'h30, 4'hD, 1'b0, 1'b0});
      run_n(6);
      chk("d2_1234", {7'h24, 4'hB, 1'b0, 1'b0});
      run_n(6);
      chk("d3_1234", {7'h79, 4'h7, 1'b0, 1'b0});

      // load coinciding with the frame tick goes straight to active
      run_until_ft("ft_coinc");
      step(1, 1, 1, 16'h0009);
      chk("coinc_p0", {7'h7F, 4'hF, 1'b0, 1'b0});
      step(1, 1, 0, 16'h0);
      chk("coinc_p1", {7'h7F, 4'hF, 1'b0, 1'b0});
      step(1, 1, 0, 16'h0);
      chk("coinc_d0", {7'h10, 4'hE, 1'b0, 1'b0});

      // enable drop during digit 2 drive
      run_n(12);
      chk("pre_drop", model_out());
      step(1, 0, 0, 16'h0);
      chk("drop", {7'h7F, 4'hF, 1'b0, 1'b0});
      step(1, 0, 0, 16'h0);
      chk("drop2", {7'h7F, 4'hF, 1'b0, 1'b0});
      step(1, 1, 0, 16'h0);
      chk("reen_gap", {7'h7F, 4'hF, 1'b0, 1'b0});
      step(1, 1, 0, 16'h0);
      chk("reen_d0", {7'h10, 4'hE, 1'b0, 1'b0});

      // mid-frame clear with 5678 on display
      step(1, 0, 1, 16'h5678);
      chk("dis_load", {7'h7F, 4'hF, 1'b1, 1'b0});
      step(1, 0, 0, 16'h0);
      chk("dis_commit", {7'h7F, 4'hF, 1'b0, 1'b0});
      run_n(2);
      chk("d0_5678", {7'h00, 4'hE, 1'b0, 1'b0});
      step(0, 1, 0, 16'h0);
      chk("clr_mid", {7'h7F, 4'hF, 1'b0, 1'b0});
      run_n(2);
      chk("clr_d0", {7'h40, 4'hE, 1'b0, 1'b0});

      // leading zeros with 0007
      step(1, 0, 1, 16'h0007);
      step(1, 0, 0, 16'h0);
      run_n(2);
      chk("lz_d0", {7'h78, 4'hE, 1'b0, 1'b0});
      run_n(6);
      chk("lz_d1", {LZ_D1, 1'b0, 1'b0});
      run_n(6);
      chk("lz_d2", {LZ_D2, 1'b0, 1'b0});
      run_n(6);
      chk("lz_d3", {LZ_D3, 1'b0, 1'b0});
      run_n(3);
      chk_bit("lz_tick", ft, 1'b1);

      // random stimulus against the reference model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63) != 0), ($urandom_range(31) != 0),
              ($urandom_range(11) == 0), 16'($urandom));
         chk($sformatf("rnd%0d", i), model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
